// File: rtl/scr1_pipe_mprf_mp.sv
// -----------------------------------------------------------------------------
// scr1_pipe_mprf_mp
//   Parametrised multi-port register file for multi-issue / extended SCR1
//   pipelines. NUM_RD read ports, NUM_WR write ports, DEPTH = 2**AWIDTH
//   entries of XLEN bits.
//
//   After reset an init sequencer walks every entry and writes zero, so the
//   storage itself never needs a reset and can map onto embedded RAM.
//   While the sequencer runs (init_busy_o = 1) writes are ignored and reads
//   return zero.
//
//   SYNC_RD = 1 : registered read (latency 1) with write-first bypass. Storage
//                 is one simple dual-port RAM per (read port, write port) pair
//                 plus a per-entry "last writer" table that selects which
//                 write-port copy holds the live value.
//   SYNC_RD = 0 : combinational read from a flop array, no bypass.
//
// Ports
//   clk          clock
//   rst          asynchronous active-high reset
//   rd_en_i      per-port read enable (registered mode only)
//   rd_addr_i    packed read addresses, port p at [p*AWIDTH +: AWIDTH]
//   rd_data_o    packed read data, port p at [p*XLEN +: XLEN]
//   wr_req_i     per-port write request
//   wr_addr_i    packed write addresses
//   wr_data_i    packed write data
//   init_busy_o  high while the clear sequence runs
// -----------------------------------------------------------------------------
module scr1_pipe_mprf_mp #(
  parameter int XLEN    = 32,
  parameter int AWIDTH  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int SYNC_RD = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*AWIDTH-1:0] rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  input  logic [NUM_WR-1:0]        wr_req_i,
  input  logic [NUM_WR*AWIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  output logic                     init_busy_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Source of a registered read result
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_BYP  = 2'd1;
  localparam logic [1:0] SRC_ARR  = 2'd2;

  // ---------------------------------------------------------------------------
  // Init sequencer
  // ---------------------------------------------------------------------------
  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [AWIDTH-1:0] init_cnt_reg;
  logic [AWIDTH-1:0] init_cnt_next;
  logic              ready;

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    if (state_reg == ST_INIT) begin
      init_cnt_next = init_cnt_reg + 1'b1;
      // Leave INIT on the same edge that clears the last entry
      if (init_cnt_reg == AWIDTH'(DEPTH - 1)) begin
        state_next = ST_READY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  assign ready       = (state_reg == ST_READY);
  assign init_busy_o = ~ready;

  // ---------------------------------------------------------------------------
  // Port unpacking and effective-write decode
  // ---------------------------------------------------------------------------
  logic [NUM_WR-1:0] wr_eff;
  logic [AWIDTH-1:0] wr_addr [NUM_WR];
  logic [XLEN-1:0]   wr_data [NUM_WR];
  logic [AWIDTH-1:0] rd_addr [NUM_RD];

  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_dec
      assign wr_addr[gi] = wr_addr_i[gi*AWIDTH +: AWIDTH];
      assign wr_data[gi] = wr_data_i[gi*XLEN +: XLEN];
      // Writes to entry 0 are dropped when it is hardwired to zero
      assign wr_eff[gi]  = wr_req_i[gi] & ready &
                           ~((ZERO_R0 != 0) && (wr_addr[gi] == '0));
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_dec
      assign rd_addr[gi] = rd_addr_i[gi*AWIDTH +: AWIDTH];
    end
  endgenerate

  generate
    if (SYNC_RD != 0) begin : g_sync
      // -----------------------------------------------------------------------
      // Write side of each RAM copy. Write port 0's copies also carry the
      // init clear; the last-writer table is cleared alongside so every
      // entry initially resolves to copy 0 (which holds zero).
      // -----------------------------------------------------------------------
      logic              cp_we   [NUM_WR];
      logic [AWIDTH-1:0] cp_addr [NUM_WR];
      logic [XLEN-1:0]   cp_data [NUM_WR];

      for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_cp
        if (gi == 0) begin : g_cp0
          assign cp_we[gi]   = ~ready | wr_eff[gi];
          assign cp_addr[gi] = ready ? wr_addr[gi] : init_cnt_reg;
          assign cp_data[gi] = ready ? wr_data[gi] : '0;
        end else begin : g_cpn
          assign cp_we[gi]   = wr_eff[gi];
          assign cp_addr[gi] = wr_addr[gi];
          assign cp_data[gi] = wr_data[gi];
        end
      end

      // Combinational last-writer lookup per read port (sampled at the read edge)
      logic [NUM_RD-1:0] lvt_rd;

      if (NUM_WR > 1) begin : g_lvt
        logic lvt_mem [DEPTH];

        always_ff @(posedge clk) begin
          if (!ready) begin
            lvt_mem[init_cnt_reg] <= 1'b0;
          end else begin
            // Ascending loop: the highest-index effective write wins
            for (int w = 0; w < NUM_WR; w++) begin
              if (wr_eff[w]) begin
                lvt_mem[wr_addr[w]] <= 1'(w);
              end
            end
          end
        end

        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_lvt_rd
          assign lvt_rd[gi] = lvt_mem[rd_addr[gi]];
        end
      end else begin : g_no_lvt
        assign lvt_rd = '0;
      end

      // -----------------------------------------------------------------------
      // RAM copies: one per (read port, write port), registered read-first
      // output. Collisions are resolved by the bypass path instead.
      // -----------------------------------------------------------------------
      logic [NUM_RD*NUM_WR*XLEN-1:0] ram_q;

      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rp
        for (genvar gj = 0; gj < NUM_WR; gj++) begin : g_wp
          logic [XLEN-1:0] mem [DEPTH];
          logic [XLEN-1:0] q_reg;

          always_ff @(posedge clk) begin
            if (cp_we[gj]) begin
              mem[cp_addr[gj]] <= cp_data[gj];
            end
            if (rd_en_i[gi]) begin
              q_reg <= mem[rd_addr[gi]];
            end
          end

          assign ram_q[(gi*NUM_WR + gj)*XLEN +: XLEN] = q_reg;
        end
      end

      // -----------------------------------------------------------------------
      // Per read port: bypass detect, result-source register, output mux.
      // The output is a mux of registers only, so it behaves as a registered
      // read and holds its value while rd_en_i is low.
      // -----------------------------------------------------------------------
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rport
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;
        logic [1:0]      src_reg;
        logic [XLEN-1:0] byp_reg;
        logic            lvt_q_reg;
        logic [XLEN-1:0] rd_word;

        always_comb begin
          byp_hit  = 1'b0;
          byp_data = '0;
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_eff[w] && (wr_addr[w] == rd_addr[gi])) begin
              byp_hit  = 1'b1;
              byp_data = wr_data[w];
            end
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            src_reg   <= SRC_ZERO;
            byp_reg   <= '0;
            lvt_q_reg <= 1'b0;
          end else if (rd_en_i[gi]) begin
            lvt_q_reg <= lvt_rd[gi];
            if (!ready || ((ZERO_R0 != 0) && (rd_addr[gi] == '0))) begin
              src_reg <= SRC_ZERO;
            end else if (byp_hit) begin
              src_reg <= SRC_BYP;
              byp_reg <= byp_data;
            end else begin
              src_reg <= SRC_ARR;
            end
          end
        end

        always_comb begin
          case (src_reg)
            SRC_BYP: rd_word = byp_reg;
            SRC_ARR: rd_word = ram_q[(gi*NUM_WR + int'(lvt_q_reg))*XLEN +: XLEN];
            default: rd_word = '0;
          endcase
        end

        assign rd_data_o[gi*XLEN +: XLEN] = rd_word;
      end
    end else begin : g_async
      // -----------------------------------------------------------------------
      // Combinational read from a flop array; a same-cycle write shows up
      // only after the edge.
      // -----------------------------------------------------------------------
      logic [XLEN-1:0] mem_reg [DEPTH];

      always_ff @(posedge clk) begin
        if (!ready) begin
          mem_reg[init_cnt_reg] <= '0;
        end else begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_eff[w]) begin
              mem_reg[wr_addr[w]] <= wr_data[w];
            end
          end
        end
      end

      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rport
        assign rd_data_o[gi*XLEN +: XLEN] =
          (!ready || ((ZERO_R0 != 0) && (rd_addr[gi] == '0))) ? '0 : mem_reg[rd_addr[gi]];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_chk_wr
      assert property (@(posedge clk) disable iff (rst)
                       wr_eff[gi] |-> !$isunknown({wr_addr[gi], wr_data[gi]}))
        else $error("mprf: X on effective write port %0d", gi);
    end
  endgenerate

  assert property (@(posedge clk) (NUM_RD >= 1) && (NUM_RD <= 4))
    else $error("mprf: NUM_RD out of range");
  assert property (@(posedge clk) (NUM_WR >= 1) && (NUM_WR <= 2))
    else $error("mprf: NUM_WR out of range");

endmodule

// File: tb/tb_scr1_pipe_mprf_mp.sv
// -----------------------------------------------------------------------------
// tb_scr1_pipe_mprf_mp
//   Directed bench. dut_a: registered read, 2 read / 2 write ports, entry 0
//   hardwired. dut_b: combinational read, 2 read / 1 write port, entry 0 is
//   an ordinary register. Both share clock and reset.
// -----------------------------------------------------------------------------
module tb_scr1_pipe_mprf_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]  a_rd_en;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_wr_req;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_busy;

  logic [1:0]  b_rd_en;
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [0:0]  b_wr_req;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  scr1_pipe_mprf_mp #(
    .XLEN(32), .AWIDTH(5), .NUM_RD(2), .NUM_WR(2), .SYNC_RD(1), .ZERO_R0(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data),
    .wr_req_i(a_wr_req), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .init_busy_o(a_busy)
  );

  scr1_pipe_mprf_mp #(
    .XLEN(32), .AWIDTH(5), .NUM_RD(2), .NUM_WR(1), .SYNC_RD(0), .ZERO_R0(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data),
    .wr_req_i(b_wr_req), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .init_busy_o(b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_rd_en  = 2'b00;
    a_wr_req = 2'b00;
    b_wr_req = 1'b0;
  endtask

  // Sample busy for 32 cycles after reset release, then expect it low.
  task automatic check_init_window(input string tag);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (a_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy_a cycle %0d: got %b expected 1", tag, i, a_busy);
      end
      checks++;
      if (b_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy_b cycle %0d: got %b expected 1", tag, i, b_busy);
      end
      tick();
    end
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_end: got a=%b b=%b expected 0 0", tag, a_busy, b_busy);
    end
  endtask

  task automatic test_reset;
    idle();
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0;
    b_rd_en = 2'b00; b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (a_busy !== 1'b1 || a_rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b data=%h expected 1 0", a_busy, a_rd_data);
    end
    rst = 1'b0;
  endtask

  // Init window with a write attempt on cycle 10 that must be ignored
  task automatic test_write_during_init;
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        a_wr_req = 2'b01; a_wr_addr[4:0] = 5'd5; a_wr_data[31:0] = 32'hDEADBEEF;
        b_wr_req = 1'b1;  b_wr_addr = 5'd5;      b_wr_data = 32'hDEADBEEF;
      end
      checks++;
      if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
        errors++;
        $display("FAIL init_busy cycle %0d: got a=%b b=%b expected 1 1", i, a_busy, b_busy);
      end
      tick();
      idle();
    end
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL init_done: got a=%b b=%b expected 0 0", a_busy, b_busy);
    end
    a_rd_en = 2'b01; a_rd_addr[4:0] = 5'd5; b_rd_addr[4:0] = 5'd5;
    #1;
    checks++;
    if (b_rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL init_write_b_r5: got %h expected 00000000", b_rd_data[31:0]);
    end
    tick();
    idle();
    checks++;
    if (a_rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL init_write_a_r5: got %h expected 00000000", a_rd_data[31:0]);
    end
  endtask

  task automatic test_init_clear;
    for (int a = 0; a < 32; a++) begin
      a_rd_en   = 2'b11;
      a_rd_addr = {5'(31 - a), 5'(a)};
      b_rd_addr = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (b_rd_data !== 64'h0) begin
        errors++;
        $display("FAIL init_clear_b addr %0d: got %h expected 0", a, b_rd_data);
      end
      tick();
      idle();
      checks++;
      if (a_rd_data !== 64'h0) begin
        errors++;
        $display("FAIL init_clear_a addr %0d: got %h expected 0", a, a_rd_data);
      end
    end
  endtask

  task automatic test_sync_bypass;
    a_wr_req = 2'b01; a_wr_addr[4:0] = 5'd7; a_wr_data[31:0] = 32'h12345678;
    a_rd_en  = 2'b11; a_rd_addr = {5'd7, 5'd7};
    tick();
    idle();
    checks++;
    if (a_rd_data !== {2{32'h12345678}}) begin
      errors++;
      $display("FAIL bypass_r7: got %h expected %h", a_rd_data, {2{32'h12345678}});
    end
    a_rd_addr = {5'd1, 5'd0};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_rd_data !== {2{32'h12345678}}) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h expected %h", i, a_rd_data, {2{32'h12345678}});
      end
    end
    // Array path on port 1 only; port 0 keeps holding
    a_rd_en = 2'b10; a_rd_addr = {5'd7, 5'd0};
    tick();
    idle();
    checks++;
    if (a_rd_data !== {2{32'h12345678}}) begin
      errors++;
      $display("FAIL array_r7: got %h expected %h", a_rd_data, {2{32'h12345678}});
    end
  endtask

  task automatic test_dual_write_collision;
    a_wr_req = 2'b11; a_wr_addr = {5'd9, 5'd9}; a_wr_data = {32'h5555FFFF, 32'hAAAA0000};
    tick();
    idle();
    a_rd_en = 2'b01; a_rd_addr[4:0] = 5'd9;
    tick();
    idle();
    checks++;
    if (a_rd_data[31:0] !== 32'h5555FFFF) begin
      errors++;
      $display("FAIL collision_r9: got %h expected 5555ffff", a_rd_data[31:0]);
    end
    // Collision with a same-cycle read: bypass must pick the higher port
    a_wr_req = 2'b11; a_wr_addr = {5'd10, 5'd10}; a_wr_data = {32'hB0B0B0B0, 32'h0A0A0A0A};
    a_rd_en  = 2'b11; a_rd_addr = {5'd10, 5'd10};
    tick();
    idle();
    checks++;
    if (a_rd_data !== {2{32'hB0B0B0B0}}) begin
      errors++;
      $display("FAIL collision_bypass_r10: got %h expected %h", a_rd_data, {2{32'hB0B0B0B0}});
    end
    // Last writer follows the most recent port: port 1 then port 0 on r11
    a_wr_req = 2'b10; a_wr_addr = {5'd11, 5'd0}; a_wr_data = {32'h11111111, 32'h0};
    tick();
    a_wr_req = 2'b01; a_wr_addr = {5'd0, 5'd11}; a_wr_data = {32'h0, 32'h22222222};
    tick();
    idle();
    // Port 0 then port 1 on r12
    a_wr_req = 2'b01; a_wr_addr = {5'd0, 5'd12}; a_wr_data = {32'h0, 32'h33333333};
    tick();
    a_wr_req = 2'b10; a_wr_addr = {5'd12, 5'd0}; a_wr_data = {32'h44444444, 32'h0};
    tick();
    idle();
    a_rd_en = 2'b11; a_rd_addr = {5'd12, 5'd11};
    tick();
    idle();
    checks++;
    if (a_rd_data !== {32'h44444444, 32'h22222222}) begin
      errors++;
      $display("FAIL last_writer: got %h expected %h", a_rd_data, {32'h44444444, 32'h22222222});
    end
  endtask

  task automatic test_zero_register;
    a_wr_req = 2'b01; a_wr_addr[4:0] = 5'd0; a_wr_data[31:0] = 32'hFFFFFFFF;
    a_rd_en  = 2'b11; a_rd_addr = {5'd0, 5'd0};
    tick();
    idle();
    checks++;
    if (a_rd_data !== 64'h0) begin
      errors++;
      $display("FAIL zero_same_cycle: got %h expected 0", a_rd_data);
    end
    a_rd_en = 2'b10; a_rd_addr = {5'd0, 5'd0};
    tick();
    idle();
    checks++;
    if (a_rd_data[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL zero_next_cycle: got %h expected 00000000", a_rd_data[63:32]);
    end
    // Entry 0 is ordinary storage in dut_b; no bypass in combinational mode
    b_wr_req = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'hFFFFFFFF;
    b_rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (b_rd_data !== 64'h0) begin
      errors++;
      $display("FAIL b_r0_same_cycle: got %h expected 0", b_rd_data);
    end
    tick();
    idle();
    checks++;
    if (b_rd_data !== {2{32'hFFFFFFFF}}) begin
      errors++;
      $display("FAIL b_r0_next_cycle: got %h expected %h", b_rd_data, {2{32'hFFFFFFFF}});
    end
  endtask

  task automatic test_async_read;
    b_wr_req = 1'b1; b_wr_addr = 5'd20; b_wr_data = 32'hCAFEF00D;
    tick();
    idle();
    b_rd_addr = {5'd20, 5'd0};
    #1;
    checks++;
    if (b_rd_data !== {32'hCAFEF00D, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL b_async_read: got %h expected %h", b_rd_data, {32'hCAFEF00D, 32'hFFFFFFFF});
    end
  endtask

  task automatic test_reset_mid_op;
    a_wr_req = 2'b01; a_wr_addr[4:0] = 5'd3; a_wr_data[31:0] = 32'h11;
    b_wr_req = 1'b1;  b_wr_addr = 5'd3;      b_wr_data = 32'h11;
    tick();
    idle();
    a_rd_en = 2'b01; a_rd_addr[4:0] = 5'd3; b_rd_addr[4:0] = 5'd3;
    tick();
    idle();
    checks++;
    if (a_rd_data[31:0] !== 32'h11 || b_rd_data[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL pre_reset_r3: got a=%h b=%h expected 11 11", a_rd_data[31:0], b_rd_data[31:0]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (a_rd_data !== 64'h0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: got data=%h busy=%b expected 0 1", a_rd_data, a_busy);
    end
    rst = 1'b0;
    check_init_window("reinit");
    a_rd_en = 2'b01; a_rd_addr[4:0] = 5'd3; b_rd_addr[4:0] = 5'd3;
    #1;
    checks++;
    if (b_rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_b_r3: got %h expected 00000000", b_rd_data[31:0]);
    end
    tick();
    idle();
    checks++;
    if (a_rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_a_r3: got %h expected 00000000", a_rd_data[31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_during_init();
    test_init_clear();
    test_sync_bypass();
    test_dual_write_collision();
    test_zero_register();
    test_async_read();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
